sb_pkt_xform: RTL and testbench

SB_PKT_XFORM -- requirements
Module: sb_pkt_xform

---
 rtl/sb_pkt_xform.sv | 150 +++++++++++++++
 tb/tb_sb_pkt_xform.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_pkt_xform.sv
// Packet stream transform: per-byte add/XOR/subtract/pass with a constant K,
// latched per packet, feeding a 2-entry skid buffer with registered in_ready.
module sb_pkt_xform #(
    parameter int         DW         = 256,
    parameter int         CW         = 32,
    parameter logic [1:0] DEFAULT_OP = 2'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [1:0]    cfg_op,
    input  logic [7:0]    cfg_k,
    output logic [CW-1:0] pkt_count,
    output logic [CW-1:0] beat_count,
    output logic          busy
);

    typedef enum logic {
        ST_SOP = 1'b0,
        ST_MID = 1'b1
    } state_t;

    state_t        state_q;
    logic [1:0]    op_q;
    logic [7:0]    k_q;
    logic          in_ready_q;
    logic [DW-1:0] main_q, main_d;
    logic          main_last_q, main_last_d;
    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          skid_last_q, skid_last_d;
    logic          skid_valid_q, skid_valid_d;
    logic [CW-1:0] pkt_count_q;
    logic [CW-1:0] beat_count_q;

    logic          in_fire;
    logic          out_fire;
    logic [1:0]    op_sel;
    logic [7:0]    k_sel;
    logic [DW-1:0] xdata;

    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d,
                                            input logic [1:0]    op,
                                            input logic [7:0]    k);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < DW / 8; i++) begin
            case (op)
                2'd0:    r[i*8 +: 8] = d[i*8 +: 8] + k;
                2'd1:    r[i*8 +: 8] = d[i*8 +: 8] ^ k;
                2'd2:    r[i*8 +: 8] = d[i*8 +: 8] - k;
                default: r[i*8 +: 8] = d[i*8 +: 8];
            endcase
        end
        return r;
    endfunction

    // The first beat of a packet uses the live config; later beats use the latched copy.
    always_comb begin
        op_sel   = (state_q == ST_SOP) ? cfg_op : op_q;
        k_sel    = (state_q == ST_SOP) ? cfg_k  : k_q;
        xdata    = xform(in_data, op_sel, k_sel);
        in_fire  = in_valid && in_ready_q;
        out_fire = main_valid_q && out_ready;
    end

    always_comb begin
        main_d       = main_q;
        main_last_d  = main_last_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_last_d  = skid_last_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d      = xdata;
                    main_last_d = in_last;
                end
            end
        end else if (in_fire) begin
            skid_d       = xdata;
            skid_last_d  = in_last;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SOP;
            op_q         <= DEFAULT_OP;
            k_q          <= 8'd0;
            in_ready_q   <= 1'b0;
            main_q       <= '0;
            main_last_q  <= 1'b0;
            main_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            pkt_count_q  <= '0;
            beat_count_q <= '0;
        end else begin
            in_ready_q   <= !skid_valid_d;
            main_q       <= main_d;
            main_last_q  <= main_last_d;
            main_valid_q <= main_valid_d;
            skid_last_q  <= skid_last_d;
            skid_valid_q <= skid_valid_d;
            if (in_fire) begin
                if (state_q == ST_SOP) begin
                    op_q <= cfg_op;
                    k_q  <= cfg_k;
                end
                state_q <= in_last ? ST_SOP : ST_MID;
            end
            if (out_fire) begin
                beat_count_q <= beat_count_q + CW'(1);
                if (main_last_q) begin
                    pkt_count_q <= pkt_count_q + CW'(1);
                end
            end
        end
    end

    // Skid payload is only meaningful while skid_valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready   = in_ready_q;
    assign out_data   = main_q;
    assign out_last   = main_last_q;
    assign out_valid  = main_valid_q;
    assign pkt_count  = pkt_count_q;
    assign beat_count = beat_count_q;
    assign busy       = (state_q == ST_MID);

endmodule

// File: tb/tb_sb_pkt_xform.sv
// Directed and randomized bench for sb_pkt_xform (DW=32, CW=8) against a
// packet-level reference model holding the beats in flight in a queue.
module tb_sb_pkt_xform;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    cfg_op;
    logic [7:0]    cfg_k;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] beat_count;
    logic          busy;

    sb_pkt_xform #(.DW(DW), .CW(CW), .DEFAULT_OP(2'd0)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_op(cfg_op), .cfg_k(cfg_k),
        .pkt_count(pkt_count), .beat_count(beat_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int          ncmp  = 0;
    int          nfail = 0;
    logic [32:0] q[$];
    int          exp_beats = 0;
    int          exp_pkts  = 0;
    logic        exp_mid   = 1'b0;
    int          act_op    = 0;
    int          act_k     = 0;
    logic        last_acc  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int op, input int k);
        logic [31:0] r;
        int b;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            b = int'((d >> (8 * i)) & 32'hFF);
            case (op)
                0:       b = (b + k) % 256;
                1:       b = b ^ k;
                2:       b = (b - k + 256) % 256;
                default: b = b;
            endcase
            r = r | (32'(b) << (8 * i));
        end
        return r;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic ordy, input logic [1:0] op, input logic [7:0] k);
        logic [32:0] e;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; out_ready = ordy; cfg_op = op; cfg_k = k;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("busy", 64'(busy), 64'(exp_mid));
        chk("beat_count", 64'(beat_count), 64'(exp_beats % 256));
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkts % 256));
        last_acc = v && in_ready;
        if (out_valid && ordy && q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", 64'(out_data), 64'(e[31:0]));
            chk("out_last", 64'(out_last), 64'(e[32]));
            exp_beats++;
            if (e[32]) exp_pkts++;
        end
        if (last_acc) begin
            if (!exp_mid) begin
                act_op = int'(op);
                act_k  = int'(k);
            end
            q.push_back({l, model(d, act_op, act_k)});
            exp_mid = !l;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 8'd0);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_beat_count", 64'(beat_count), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        q.delete();
        exp_beats = 0; exp_pkts = 0; exp_mid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        int acc;
        int bc0;
        in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_op = 2'd0; cfg_k = 8'd0; rst = 1'b0;
        #1;
        do_reset();

        // Single-beat add with byte wrap and no carry propagation.
        cycle(1'b1, 32'h00FF7F10, 1'b1, 1'b1, 2'd0, 8'd1);
        chk("add_k1_data", 64'(out_data), 64'h01008011);
        chk("add_k1_last", 64'(out_last), 64'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 8'd0);
        chk("add_k1_pkts", 64'(pkt_count), 64'd1);
        chk("add_k1_beats", 64'(beat_count), 64'd1);

        // XOR packet; cfg_op switched to add mid-packet must be ignored.
        d = $urandom;
        cycle(1'b1, d, 1'b0, 1'b1, 2'd1, 8'hA5);
        chk("xor_first", 64'(out_data), 64'(d ^ 32'hA5A5A5A5));
        chk("xor_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            cycle(1'b1, d, i == 2, 1'b1, 2'd0, 8'h11);
            chk("xor_held", 64'(out_data), 64'(d ^ 32'hA5A5A5A5));
        end
        d = $urandom;
        cycle(1'b1, d, 1'b0, 1'b1, 2'd0, 8'h03);
        cycle(1'b1, $urandom, 1'b1, 1'b1, 2'd3, 8'h77);
        drain();

        // Subtract wrap and pass-through.
        cycle(1'b1, 32'h00000000, 1'b1, 1'b1, 2'd2, 8'd1);
        chk("sub_wrap", 64'(out_data), 64'hFFFFFFFF);
        d = $urandom;
        cycle(1'b1, d, 1'b1, 1'b1, 2'd3, 8'h5A);
        chk("pass", 64'(out_data), 64'(d));
        drain();

        // Ten beats with out_ready toggling; skid full must block ingress.
        bc0 = int'(beat_count);
        acc = 0;
        for (int c = 0; c < 100 && acc < 10; c++) begin
            cycle(1'b1, $urandom, acc == 9, (c % 2) == 0, 2'd1, 8'h3C);
            if (last_acc) acc++;
        end
        chk("toggle_accepted", 64'(acc), 64'd10);
        drain();
        chk("toggle_beats", 64'(beat_count), 64'((bc0 + 10) % 256));

        // Random traffic with random config and back-pressure.
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        drain();
        if (exp_mid) begin
            cycle(1'b1, $urandom, 1'b1, 1'b1, 2'd0, 8'd0);
            drain();
        end

        // Reset with two beats buffered mid-packet.
        cycle(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 8'd9);
        cycle(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 8'd9);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        do_reset();
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 8'd0);
        chk("post_rst_no_residue", 64'(out_valid), 64'd0);

        // 256 single-beat packets wrap both counters to zero.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, $urandom, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        drain();
        chk("wrap_pkts", 64'(pkt_count), 64'd0);
        chk("wrap_beats", 64'(beat_count), 64'd0);

        // Clean packet after everything.
        d = $urandom;
        cycle(1'b1, d, 1'b0, 1'b1, 2'd0, 8'h10);
        cycle(1'b1, $urandom, 1'b1, 1'b1, 2'd2, 8'h01);
        drain();
        chk("final_pkts", 64'(pkt_count), 64'd1);
        chk("final_beats", 64'(beat_count), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
